// File: rtl/down_counter_nbit_pkg.sv
// Shared encodings and defaults for the loadable down counter and its controller.
package counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/down_counter_nbit_if.sv
// Handshake/data bundle between a controller (master) and the down counter (slave).
interface down_counter_nbit_if
  import counter_pkg::*;
#(
  parameter int W = CNT_W_DEF
);

  logic         ldcnt;
  logic         en;
  logic         ack;
  logic [W-1:0] data;
  logic [W-1:0] cnt;
  logic         borrow;
  logic         busy;
  logic         done;
  logic         tc;

  modport master (
    output ldcnt, en, ack, data,
    input  cnt, borrow, busy, done, tc
  );

  modport slave (
    input  ldcnt, en, ack, data,
    output cnt, borrow, busy, done, tc
  );

endinterface

// File: rtl/down_counter_nbit_ctrl.sv
// Control FSM for the down counter: issues load/dec/reload strobes and the tc pulse.
//   state   | meaning
//   S_IDLE  | waiting for ldcnt, cnt held
//   S_COUNT | decrementing on en, busy = 1
//   S_DONE  | count expired, done = 1 until ack or reload
module down_counter_ctrl
  import counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ldcnt,
  input  logic en,
  input  logic ack,
  input  logic data_zero,
  input  logic cnt_le_one,
  input  logic reload_ok,
  output logic load,
  output logic dec,
  output logic reload,
  output logic busy,
  output logic done,
  output logic tc
);

  state_t state_q, state_d;
  logic   tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    reload  = 1'b0;
    tc_d    = 1'b0;
    if (ldcnt) begin
      load = 1'b1;
      if (data_zero) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = S_COUNT;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_COUNT: begin
          if (en) begin
            // reload_ok is only ever high in the auto-reload build
            if (cnt_le_one && reload_ok) begin
              reload = 1'b1;
              tc_d   = 1'b1;
            end else begin
              dec = 1'b1;
              if (cnt_le_one) begin
                state_d = S_DONE;
                tc_d    = 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_COUNT);
  assign done = (state_q == S_DONE);
  assign tc   = tc_q;

endmodule

// File: rtl/down_counter_nbit.sv
// Loadable W-bit down counter with busy/done/ack handshake and terminal-count pulse.
// Build option DOWN_COUNTER_AUTO_RELOAD_EN turns it into a periodic tick generator.
module down_counter_nbit
  import counter_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  down_counter_nbit_if.slave bus
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_val;
  logic         reload_ok;
  logic         load, dec, reload;
  logic         busy, done, tc;
  logic         cnt_zero, cnt_le_one;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    if (bus.ldcnt) reload_d = bus.data;
  end

  always_ff @(posedge clk) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end

  assign reload_val = reload_q;
  assign reload_ok  = (reload_q != '0);
`else
  assign reload_val = '0;
  assign reload_ok  = 1'b0;
`endif

  assign cnt_zero   = (cnt_q == '0);
  assign cnt_le_one = (cnt_q <= {{(W-1){1'b0}}, 1'b1});

  down_counter_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ldcnt      (bus.ldcnt),
    .en         (bus.en),
    .ack        (bus.ack),
    .data_zero  (bus.data == '0),
    .cnt_le_one (cnt_le_one),
    .reload_ok  (reload_ok),
    .load       (load),
    .dec        (dec),
    .reload     (reload),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  // decrement saturates at zero so cnt can never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = bus.data;
    else if (reload)            cnt_d = reload_val;
    else if (dec && !cnt_zero)  cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.cnt    = cnt_q;
  assign bus.borrow = cnt_zero;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.tc     = tc;

endmodule

// File: tb/tb_down_counter_nbit.sv
// Scoreboard bench for down_counter_nbit: directed vectors push expectations, a monitor checks them.
module tb_down_counter_nbit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  down_counter_nbit_if #(.W(4)) bus ();

  down_counter_nbit #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] vec;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // expected vector: {cnt, borrow, busy, done, tc}
  task automatic step(input logic r, input logic l, input logic [3:0] d,
                      input logic e, input logic a,
                      input logic [3:0] xc, input logic xbusy, input logic xdone,
                      input logic xtc, input string nm);
    exp_t x;
    rst       = r;
    bus.ldcnt = l;
    bus.data  = d;
    bus.en    = e;
    bus.ack   = a;
    @(posedge clk);
    x.vec  = {xc, (xc == 4'd0), xbusy, xdone, xtc};
    x.name = nm;
    q.push_back(x);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {bus.cnt, bus.borrow, bus.busy, bus.done, bus.tc};
        n_chk++;
        if (act !== x.vec) begin
          n_fail++;
          $display("FAIL %s: got cnt=%0d borrow=%b busy=%b done=%b tc=%b, want cnt=%0d borrow=%b busy=%b done=%b tc=%b",
                   x.name, act[7:4], act[3], act[2], act[1], act[0],
                   x.vec[7:4], x.vec[3], x.vec[2], x.vec[1], x.vec[0]);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; bus.ldcnt = 1'b0; bus.data = '0; bus.en = 1'b0; bus.ack = 1'b0;
    @(negedge clk);
    //    r  l  d      e  a   cnt    busy  done  tc
    step(1, 1, 4'hA, 0, 0, 4'd0, 0, 0, 0, "reset0");
    step(1, 1, 4'hA, 0, 0, 4'd0, 0, 0, 0, "reset1");
    step(0, 0, 4'h0, 1, 1, 4'd0, 0, 0, 0, "idle_ignore");
    step(0, 1, 4'h0, 0, 0, 4'd0, 0, 1, 1, "load0_done");
    step(0, 0, 4'h0, 0, 0, 4'd0, 0, 1, 0, "load0_hold");
    step(0, 1, 4'h0, 0, 0, 4'd0, 0, 1, 1, "load0_reenter");
    step(0, 0, 4'h0, 0, 1, 4'd0, 0, 0, 0, "load0_ack");
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    step(0, 1, 4'h3, 1, 0, 4'd3, 1, 0, 0, "ar_load");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "ar_2");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 0, "ar_1");
    step(0, 0, 4'h0, 1, 0, 4'd3, 1, 0, 1, "ar_reload1");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "ar_2b");
    step(0, 0, 4'h0, 0, 0, 4'd2, 1, 0, 0, "ar_en_off");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 0, "ar_1b");
    step(0, 0, 4'h0, 1, 1, 4'd3, 1, 0, 1, "ar_reload2");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "ar_2c");
    step(0, 1, 4'h0, 1, 0, 4'd0, 0, 1, 1, "ar_stop");
    step(0, 0, 4'h0, 0, 1, 4'd0, 0, 0, 0, "ar_ack");
    step(0, 1, 4'h1, 1, 0, 4'd1, 1, 0, 0, "ar_load1");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 1, "ar_period1");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 1, "ar_period1b");
    step(1, 1, 4'h5, 1, 0, 4'd0, 0, 0, 0, "ar_rst");
`else
    step(0, 1, 4'h3, 1, 0, 4'd3, 1, 0, 0, "basic_load");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "basic_2");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 0, "basic_1");
    step(0, 0, 4'h0, 1, 0, 4'd0, 0, 1, 1, "basic_done");
    step(0, 0, 4'h0, 1, 0, 4'd0, 0, 1, 0, "basic_hold");
    step(0, 0, 4'h0, 0, 1, 4'd0, 0, 0, 0, "basic_ack");
    step(0, 1, 4'h5, 0, 0, 4'd5, 1, 0, 0, "gate_load");
    step(0, 0, 4'h0, 1, 0, 4'd4, 1, 0, 0, "gate_e1");
    step(0, 0, 4'h0, 0, 0, 4'd4, 1, 0, 0, "gate_e0a");
    step(0, 0, 4'h0, 1, 0, 4'd3, 1, 0, 0, "gate_e1b");
    step(0, 0, 4'h0, 0, 1, 4'd3, 1, 0, 0, "gate_ack_in_count");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "gate_e1c");
    step(0, 0, 4'h0, 0, 0, 4'd2, 1, 0, 0, "gate_e0c");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 0, "gate_e1d");
    step(0, 0, 4'h0, 0, 0, 4'd1, 1, 0, 0, "gate_e0d");
    step(0, 0, 4'h0, 1, 0, 4'd0, 0, 1, 1, "gate_done");
    step(0, 0, 4'h0, 0, 0, 4'd0, 0, 1, 0, "gate_hold");
    step(0, 1, 4'h2, 0, 1, 4'd2, 1, 0, 0, "ackld_restart");
    step(0, 0, 4'h0, 1, 0, 4'd1, 1, 0, 0, "ackld_1");
    step(0, 0, 4'h0, 1, 0, 4'd0, 0, 1, 1, "ackld_done");
    step(0, 0, 4'h0, 0, 1, 4'd0, 0, 0, 0, "ackld_ack");
    step(0, 1, 4'h4, 1, 0, 4'd4, 1, 0, 0, "abort_load");
    step(0, 0, 4'h0, 1, 0, 4'd3, 1, 0, 0, "abort_3");
    step(0, 0, 4'h0, 1, 0, 4'd2, 1, 0, 0, "abort_2");
    step(0, 1, 4'h7, 1, 0, 4'd7, 1, 0, 0, "abort_reload");
    step(0, 0, 4'h0, 1, 0, 4'd6, 1, 0, 0, "abort_6");
    step(1, 1, 4'h9, 1, 0, 4'd0, 0, 0, 0, "rst_over_ld");
    step(0, 1, 4'h1, 1, 0, 4'd1, 1, 0, 0, "n1_load");
    step(0, 0, 4'h0, 1, 0, 4'd0, 0, 1, 1, "n1_done");
    step(0, 1, 4'hF, 1, 1, 4'd15, 1, 0, 0, "max_load");
    step(0, 0, 4'h0, 1, 0, 4'd14, 1, 0, 0, "max_dec");
    step(1, 0, 4'h0, 0, 0, 4'd0, 0, 0, 0, "final_rst");
`endif
    rst = 1'b0; bus.ldcnt = 1'b0; bus.en = 1'b0; bus.ack = 1'b0;
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_nbit.md
Name: down_counter_nbit

Overview:
Parameterised loadable down counter with a small control FSM. It is the counterpart of the team's 2-bit loadable up counter: it counts down from a loaded value to zero and raises a borrow flag instead of a carry. It adds a busy/done/ack handshake so a controller can launch a count and be told when it expires. It is used as the iteration and delay timer in datapath/controller designs.

Parameters:
W, 4, counter width in bits (W >= 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
ldcnt  input  1  load: cnt <= data, start counting
en  input  1  count enable; decrement only when high in COUNT
ack  input  1  acknowledges done; returns FSM to IDLE
data  input  W  load value
cnt  output  W  current count (registered)
borrow  output  1  combinational, high when cnt == 0
busy  output  1  high in COUNT
done  output  1  high in DONE, held until ack
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, cnt = 0, busy = 0, done = 0, tc = 0, and therefore borrow = 1.
- Priority in every state: rst > ldcnt > ack > en.
- States: IDLE, COUNT, DONE (2-bit encoding). busy and done are decoded from the state register, so they have no extra latency.
- IDLE: cnt holds.
  - ldcnt: cnt <= data; go to COUNT if data != 0, otherwise go to DONE.
  - ack and en are ignored.
- COUNT, with en = 1:
  - cnt > 1: cnt <= cnt - 1.
  - cnt == 1: cnt <= 0, go to DONE.
- COUNT, with en = 0: cnt and state hold.
- DONE: cnt holds at 0; done = 1.
  - ack: go to IDLE.
  - ldcnt (even together with ack): reload and restart as described for IDLE.
- ldcnt in COUNT or DONE aborts the current count and restarts from data on the same edge.
- Latency: for a load value N > 0 with en held high, the first cycle in DONE is N cycles after the ldcnt edge.
- tc is registered. It is 1 in the first cycle of DONE, i.e. on the edge that enters DONE, including an immediate entry after a load of 0. It is 0 in all other cycles.
- Arithmetic is unsigned modulo 2^W. cnt never decrements below 0 (no wrap-around in COUNT).
- rst in any state overrides everything, including a simultaneous ldcnt.

Optional Feature:
Macro: DOWN_COUNTER_AUTO_RELOAD_EN
- Defined:
  - A W-bit reload register captures data on every ldcnt.
  - In COUNT with cnt == 1 and en = 1: cnt <= reload and the FSM stays in COUNT. tc pulses in the next cycle, giving a periodic tick every reload enabled cycles.
  - Leaving COUNT requires ldcnt with data = 0 (goes to DONE) or rst.
  - A reload value of 0 behaves as in the non-defined build.
  - The reload register resets to 0.
- Not defined: no reload register; behaviour is exactly as described above.

Decomposition:
- Shared package counter_pkg:
  - state encodings S_IDLE = 2'd0, S_COUNT = 2'd1, S_DONE = 2'd2
  - default width constant CNT_W_DEF = 4
- One natural sub-module, down_counter_ctrl:
  - the FSM, next-state logic and tc register
  - drives load and dec strobes into the cnt register in the top module
- borrow is a comparator in the top module.

Test Plan:
- Reset: rst high for 2 cycles with ldcnt = 1, data = 4'hA -> cnt = 0, borrow = 1, busy = 0, done = 0, tc = 0.
- Basic count: ldcnt with data = 3, en held high -> cnt sequence 3, 2, 1, 0; DONE with tc = 1 three cycles after load; done stays high until ack, then IDLE.
- Enable gating: data = 5, en toggled 1,0,1,0,... -> cnt decrements only in en-high cycles; done asserts after 5 en-high cycles.
- Load zero and abort:
  - data = 0 -> DONE on the next edge, tc = 1, borrow = 1.
  - ldcnt with data = 7 while COUNT at cnt = 2 -> cnt = 7, stays busy, no tc.
- Simultaneous events:
  - ack + ldcnt (data = 2) in DONE -> COUNT with cnt = 2.
  - rst + ldcnt -> IDLE with cnt = 0.
- Auto-reload (macro defined): data = 3, en held high -> cnt sequence 3, 2, 1, 3, 2, 1, ...; tc pulses every 3 cycles; done never asserts.
